// File: rtl/alarm_timer_unit.sv
// Alarm time register with match flags, a snooze countdown and a beep
// generator that modulates the buzzer while the control unit requests a ring.
module alarm_timer_unit #(
   parameter int SNOOZE_SECS = 300,
   parameter int BEEP_DIV    = 25000000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Tick,
   input  logic [4:0] Cur_Hour,
   input  logic [5:0] Cur_Min,
   input  logic       Set_Alarm,
   input  logic [4:0] Set_Hour,
   input  logic [5:0] Set_Min,
   input  logic       Alarm_On,
   input  logic       EN_SNZ,
   input  logic       Sound,
   output logic       AA,
   output logic       C0,
   output logic       CS0,
   output logic [4:0] Alarm_Hour,
   output logic [5:0] Alarm_Min,
   output logic [9:0] Snz_Remain,
   output logic       Buzzer
);

   localparam logic [9:0]  SNZ_LOAD = 10'(SNOOZE_SECS);
   localparam logic [24:0] DIV_LAST = 25'(BEEP_DIV - 1);

   logic [4:0]  alarm_hour_q, alarm_hour_d;
   logic [5:0]  alarm_min_q, alarm_min_d;
   logic        aa_q, aa_d;
   logic        c0_q, c0_d;
   logic [9:0]  snz_q, snz_d;
   logic [24:0] div_q, div_d;
   logic        phase_q, phase_d;
   logic        buzzer_q, buzzer_d;
   logic        match;

   // Compared against the stored alarm, so a same-edge load takes effect one cycle later.
   assign match = (Cur_Hour == alarm_hour_q) && (Cur_Min == alarm_min_q);

   // NOTE: every _d gets a default first so no path through the block infers a latch.
   always_comb begin
      alarm_hour_d = alarm_hour_q;
      alarm_min_d  = alarm_min_q;
      snz_d        = snz_q;
      div_d        = 25'd0;
      phase_d      = 1'b1;
      buzzer_d     = 1'b0;
      aa_d         = Alarm_On & match;
      c0_d         = ~match;

      if (Set_Alarm && (Set_Hour <= 5'd23) && (Set_Min <= 6'd59)) begin
         alarm_hour_d = Set_Hour;
         alarm_min_d  = Set_Min;
      end

      // Load beats decrement; the countdown saturates at zero.
      if (EN_SNZ) begin
         snz_d = SNZ_LOAD;
      end else if (Tick && (snz_q != 10'd0)) begin
         snz_d = snz_q - 10'd1;
      end

      if (Sound) begin
         buzzer_d = phase_q;
         phase_d  = phase_q;
         if (div_q == DIV_LAST) begin
            div_d   = 25'd0;
            phase_d = ~phase_q;
         end else begin
            div_d = div_q + 25'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         alarm_hour_q <= 5'd0;
         alarm_min_q  <= 6'd0;
         aa_q         <= 1'b0;
         c0_q         <= 1'b0;
         snz_q        <= 10'd0;
         div_q        <= 25'd0;
         phase_q      <= 1'b1;
         buzzer_q     <= 1'b0;
      end else begin
         alarm_hour_q <= alarm_hour_d;
         alarm_min_q  <= alarm_min_d;
         aa_q         <= aa_d;
         c0_q         <= c0_d;
         snz_q        <= snz_d;
         div_q        <= div_d;
         phase_q      <= phase_d;
         buzzer_q     <= buzzer_d;
      end
   end

   assign AA         = aa_q;
   assign C0         = c0_q;
   assign CS0        = (snz_q == 10'd0);
   assign Alarm_Hour = alarm_hour_q;
   assign Alarm_Min  = alarm_min_q;
   assign Snz_Remain = snz_q;
   assign Buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_timer_unit.sv
// Directed bench for alarm_timer_unit: alarm match, load validation, snooze
// countdown, beep timing and asynchronous reset.
module tb_alarm_timer_unit;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Tick;
   logic [4:0] Cur_Hour;
   logic [5:0] Cur_Min;
   logic       Set_Alarm;
   logic [4:0] Set_Hour;
   logic [5:0] Set_Min;
   logic       Alarm_On;
   logic       EN_SNZ;
   logic       Sound;

   logic       AA, C0, CS0, Buzzer;
   logic [4:0] Alarm_Hour;
   logic [5:0] Alarm_Min;
   logic [9:0] Snz_Remain;

   logic       AA2, C02, CS02, Buzzer2;
   logic [4:0] Alarm_Hour2;
   logic [5:0] Alarm_Min2;
   logic [9:0] Snz_Remain2;

   int vectors = 0;
   int miscompares = 0;

   alarm_timer_unit #(.SNOOZE_SECS(3), .BEEP_DIV(4)) u_dut (
      .Clk(Clk), .Reset(Reset), .Tick(Tick), .Cur_Hour(Cur_Hour), .Cur_Min(Cur_Min),
      .Set_Alarm(Set_Alarm), .Set_Hour(Set_Hour), .Set_Min(Set_Min),
      .Alarm_On(Alarm_On), .EN_SNZ(EN_SNZ), .Sound(Sound),
      .AA(AA), .C0(C0), .CS0(CS0), .Alarm_Hour(Alarm_Hour), .Alarm_Min(Alarm_Min),
      .Snz_Remain(Snz_Remain), .Buzzer(Buzzer)
   );

   // Second instance with a long snooze, used for the mid-snooze reset case.
   alarm_timer_unit #(.SNOOZE_SECS(150), .BEEP_DIV(4)) u_dut_long (
      .Clk(Clk), .Reset(Reset), .Tick(Tick), .Cur_Hour(Cur_Hour), .Cur_Min(Cur_Min),
      .Set_Alarm(Set_Alarm), .Set_Hour(Set_Hour), .Set_Min(Set_Min),
      .Alarm_On(Alarm_On), .EN_SNZ(EN_SNZ), .Sound(Sound),
      .AA(AA2), .C0(C02), .CS0(CS02), .Alarm_Hour(Alarm_Hour2), .Alarm_Min(Alarm_Min2),
      .Snz_Remain(Snz_Remain2), .Buzzer(Buzzer2)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick_once();
      Tick = 1'b1;
      step();
      Tick = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; Tick = 1'b0; Cur_Hour = 5'd0; Cur_Min = 6'd0;
      Set_Alarm = 1'b0; Set_Hour = 5'd0; Set_Min = 6'd0;
      Alarm_On = 1'b0; EN_SNZ = 1'b0; Sound = 1'b0;

      #2;
      check("rst_aa", AA, 0);
      check("rst_c0", C0, 0);
      check("rst_cs0", CS0, 1);
      check("rst_snz", Snz_Remain, 0);
      check("rst_buzzer", Buzzer, 0);
      check("rst_hour", Alarm_Hour, 0);
      check("rst_min", Alarm_Min, 0);

      @(negedge Clk);
      Reset = 1'b1;

      // Load 06:30 while current time is 06:29; match uses the old 00:00.
      Set_Alarm = 1'b1; Set_Hour = 5'd6; Set_Min = 6'd30;
      Cur_Hour = 5'd6; Cur_Min = 6'd29; Alarm_On = 1'b1;
      step();
      Set_Alarm = 1'b0;
      check("load_hour", Alarm_Hour, 6);
      check("load_min", Alarm_Min, 30);
      check("load_edge_aa", AA, 0);
      check("load_edge_c0", C0, 1);

      step();
      check("0629_aa", AA, 0);
      check("0629_c0", C0, 1);
      Cur_Min = 6'd30;
      step();
      check("0630_aa", AA, 1);
      check("0630_c0", C0, 0);
      Cur_Min = 6'd31;
      step();
      check("0631_aa", AA, 0);
      check("0631_c0", C0, 1);

      // Disarming clears AA but leaves C0 tracking the match.
      Cur_Min = 6'd30;
      step();
      check("rearm_aa", AA, 1);
      Alarm_On = 1'b0;
      step();
      check("disarm_aa", AA, 0);
      check("disarm_c0", C0, 0);
      Alarm_On = 1'b1;

      Set_Alarm = 1'b1; Set_Hour = 5'd24; Set_Min = 6'd10;
      step();
      check("bad_hour_h", Alarm_Hour, 6);
      check("bad_hour_m", Alarm_Min, 30);
      Set_Hour = 5'd7; Set_Min = 6'd60;
      step();
      check("bad_min_h", Alarm_Hour, 6);
      check("bad_min_m", Alarm_Min, 30);
      Set_Alarm = 1'b0;

      EN_SNZ = 1'b1;
      step();
      EN_SNZ = 1'b0;
      check("snz_load", Snz_Remain, 3);
      check("snz_load_cs0", CS0, 0);
      check("snz_long_load", Snz_Remain2, 150);
      tick_once();
      check("snz_t1", Snz_Remain, 2);
      check("snz_t1_cs0", CS0, 0);
      step();
      check("snz_hold", Snz_Remain, 2);
      tick_once();
      check("snz_t2", Snz_Remain, 1);
      check("snz_t2_cs0", CS0, 0);
      tick_once();
      check("snz_t3", Snz_Remain, 0);
      check("snz_t3_cs0", CS0, 1);
      tick_once();
      check("snz_t4_sat", Snz_Remain, 0);
      check("snz_t4_cs0", CS0, 1);

      tick_once();
      EN_SNZ = 1'b1; Tick = 1'b1;
      step();
      EN_SNZ = 1'b0; Tick = 1'b0;
      check("snz_load_tick", Snz_Remain, 3);
      tick_once();
      check("snz_after_coinc", Snz_Remain, 2);

      Sound = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("beep_%0d", i), Buzzer, (i < 4) ? 1 : (i < 8) ? 0 : 1);
      end
      Sound = 1'b0;
      step();
      check("beep_off", Buzzer, 0);
      Sound = 1'b1;
      step();
      check("beep_restart", Buzzer, 1);

      // Abort mid-snooze and mid-ring with an asynchronous reset.
      EN_SNZ = 1'b1;
      step();
      EN_SNZ = 1'b0;
      tick_once();
      check("pre_rst_long", Snz_Remain2, 149);
      check("pre_rst_aa", AA, 1);
      Reset = 1'b0;
      #1;
      check("async_snz_long", Snz_Remain2, 0);
      check("async_cs0_long", CS02, 1);
      check("async_snz", Snz_Remain, 0);
      check("async_aa", AA, 0);
      check("async_buzzer", Buzzer, 0);
      check("async_hour", Alarm_Hour, 0);
      check("async_min", Alarm_Min, 0);
      check("async_c0", C0, 0);

      @(negedge Clk);
      Reset = 1'b1;
      Sound = 1'b0;
      step();
      check("post_rst_c0", C0, 1);
      check("post_rst_aa", AA, 0);
      check("post_rst_snz", Snz_Remain2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alarm_timer_unit.md
ALARM_TIMER_UNIT -- requirements
Module: alarm_timer_unit

Interface
REQ-001 Parameter SNOOZE_SECS, 300, snooze length in seconds (1..1023).
REQ-002 Parameter BEEP_DIV, 25000000, buzzer half-period in Clk cycles (>=2).
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Tick  input  1  one-second strobe, exactly one Clk cycle wide.
REQ-006 Cur_Hour  input  5  current hour, 0..23; Cur_Min  input  6  current minute, 0..59.
REQ-007 Set_Alarm  input  1  load strobe for the alarm time.
REQ-008 Set_Hour  input  5  / Set_Min  input  6  alarm time to load.
REQ-009 Alarm_On  input  1  alarm armed.
REQ-010 EN_SNZ  input  1  snooze-start pulse from the alarm control unit.
REQ-011 Sound  input  1  ring request from the alarm control unit.
REQ-012 AA  output  1  alarm-active: armed and current HH:MM equals alarm HH:MM.
REQ-013 C0  output  1  alarm minute over: current HH:MM differs from alarm HH:MM.
REQ-014 CS0  output  1  snooze counter is zero.
REQ-015 Alarm_Hour  output  5  / Alarm_Min  output  6  stored alarm time.
REQ-016 Snz_Remain  output  10  seconds left in snooze.
REQ-017 Buzzer  output  1  beep-modulated buzzer drive.

Function
REQ-018 Alarm register SHALL load Set_Hour/Set_Min on a Clk edge with Set_Alarm=1 only if Set_Hour<=23 and Set_Min<=59; out-of-range requests SHALL leave the register unchanged.
REQ-019 Match SHALL be (Cur_Hour==Alarm_Hour) and (Cur_Min==Alarm_Min), evaluated against the stored alarm register value before any same-edge load.
REQ-020 AA SHALL be registered: AA <= Alarm_On and Match, one Clk cycle latency.
REQ-021 C0 SHALL be registered: C0 <= not Match, one Clk cycle latency, independent of Alarm_On.
REQ-022 Snooze counter (10 bits) SHALL load SNOOZE_SECS on any edge with EN_SNZ=1; otherwise decrement by 1 on an edge with Tick=1 and count!=0; otherwise hold.
REQ-023 EN_SNZ and Tick on the same edge: load SHALL win, no decrement.
REQ-024 Counter at 0 with Tick SHALL stay 0 (no wrap to 1023).
REQ-025 CS0 SHALL equal (counter==0) decoded from the register; Snz_Remain SHALL equal the counter.
REQ-026 In the cycle after an EN_SNZ load, CS0 SHALL be 0 (SNOOZE_SECS>=1).
REQ-027 Beep generator: divider counter (25 bits) and phase bit; while Sound=0, divider<=0, phase<=1, Buzzer<=0.
REQ-028 While Sound=1: Buzzer<=phase; divider increments, and when divider==BEEP_DIV-1 it SHALL wrap to 0 and phase SHALL toggle.
REQ-029 Buzzer SHALL therefore go high one cycle after Sound rises and toggle every BEEP_DIV cycles; Sound falling SHALL force Buzzer low on the next edge.
REQ-030 Alarm_On deassertion SHALL clear AA on the next edge and SHALL NOT affect the snooze counter or C0.

Reset
REQ-031 Reset=0 SHALL immediately, without Clk, set: alarm register 00:00, AA=0, C0=0, snooze counter=0 (CS0=1), divider=0, phase=1, Buzzer=0.
REQ-032 Reset assertion mid-snooze or mid-ring SHALL abort the operation; after release all counters restart from reset values.
REQ-033 Reset release SHALL be synchronized externally; first state update on the first Clk rising edge with Reset=1.

Verification
REQ-034 Set 06:30 valid, Alarm_On=1, Cur time 06:29 -> 06:30 -> AA=0,C0=1 then AA=1,C0=0 one cycle after Cur_Min changes; 06:31 -> AA=0,C0=1.
REQ-035 Set_Alarm with Set_Hour=24 or Set_Min=60 -> Alarm_Hour/Alarm_Min unchanged.
REQ-036 SNOOZE_SECS=3: EN_SNZ pulse, then 4 Ticks -> Snz_Remain 3,2,1,0,0; CS0 rises only after third Tick; EN_SNZ coincident with Tick -> Snz_Remain=3.
REQ-037 BEEP_DIV=4, Sound held 12 cycles -> Buzzer 1 for 4 cycles, 0 for 4, 1 for 4; Sound low -> Buzzer 0 next cycle.
REQ-038 Reset pulse mid-snooze (Snz_Remain=150) -> Snz_Remain=0, CS0=1, AA=0, Buzzer=0 immediately, alarm time 00:00.
